// File: rtl/game_pkg.sv
// Shared definitions for the 2048 move controller: state codes, direction bits,
// board geometry and cell access helpers.
package game_pkg;

  localparam int EXP_W   = 4;
  localparam int CELLS   = 16;
  localparam int BOARD_W = EXP_W * CELLS;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam logic [1:0]  ES_PLAY    = 2'b00;
  localparam logic [1:0]  ES_WON     = 2'b01;
  localparam logic [1:0]  ES_LOST    = 2'b10;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_LINE  = 3'd2,
    ST_SPAWN = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHECK = 3'd5,
    ST_OVER  = 3'd6,
    ST_INIT  = 3'd7
  } state_e;

  typedef logic [EXP_W-1:0] exp_t;
  typedef logic [3:0]       cell_idx_t;

  // Element 0 of every line is the cell nearest the side the tiles slide toward.
  function automatic cell_idx_t cell_index(input logic [3:0] dir, input logic [1:0] line,
                                           input logic [1:0] elem);
    logic [1:0] inv;
    inv = 2'd3 - elem;
    if (dir[DIR_RIGHT]) begin
      return {line, inv};
    end else if (dir[DIR_UP]) begin
      return {elem, line};
    end else if (dir[DIR_DOWN]) begin
      return {inv, line};
    end else begin
      return {line, elem};
    end
  endfunction

  function automatic exp_t get_cell(input logic [BOARD_W-1:0] b, input cell_idx_t idx);
    return b[(CELLS - 1 - int'(idx)) * EXP_W +: EXP_W];
  endfunction

  function automatic logic [BOARD_W-1:0] set_cell(input logic [BOARD_W-1:0] b,
                                                  input cell_idx_t idx, input exp_t v);
    logic [BOARD_W-1:0] r;
    r = b;
    r[(CELLS - 1 - int'(idx)) * EXP_W +: EXP_W] = v;
    return r;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] d);
    return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/line_merge.sv
// Slides one 4-cell line toward element 0 and merges equal neighbours once.
module line_merge
  import game_pkg::*;
(
  input  logic [3:0][EXP_W-1:0] line_i,
  output logic [3:0][EXP_W-1:0] line_o
);

  // Entry 4 stays empty so the last compacted cell never finds a partner.
  exp_t       cmp [0:4];
  logic [2:0] n;
  logic [2:0] k;
  logic       skip;

  // Compact nonzero cells, then fold pairs from element 0 upward; exponent 15 never folds.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cmp[i] = '0;
    end
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (line_i[i] != '0) begin
        cmp[n] = line_i[i];
        n      = n + 3'd1;
      end else begin
        n = n;
      end
    end
    line_o = '0;
    k      = 3'd0;
    skip   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp[i] != '0) begin
        if ((cmp[i] == cmp[i+1]) && (cmp[i] != {EXP_W{1'b1}})) begin
          line_o[k[1:0]] = cmp[i] + 4'd1;
          skip           = 1'b1;
        end else begin
          line_o[k[1:0]] = cmp[i];
        end
        k = k + 3'd1;
      end else begin
        skip = 1'b0;
      end
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// 2048 move controller: takes one key press, slides/merges the board one line per cycle,
// spawns an LFSR-chosen tile, writes the board back and evaluates win/lose.
module move_sequencer
  import game_pkg::*;
#(
  parameter int          WIN_EXP   = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clock,
  input  logic               start,
  input  logic [3:0]         direction,
  input  logic [BOARD_W-1:0] oldvalues,
  output logic               enable,
  output logic [BOARD_W-1:0] newvalues,
  output logic [1:0]         endstatus,
  output logic [2:0]         state
);

  state_e             state_q, state_d;
  logic [BOARD_W-1:0] board_q, board_d, saved_q, saved_d, newvalues_q, newvalues_d;
  logic [1:0]         line_q, line_d, endstatus_q, endstatus_d;
  logic [3:0]         dir_q, dir_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               armed_q, armed_d, enable_q, enable_d;

  logic [3:0][EXP_W-1:0] line_in, line_out;
  logic [BOARD_W-1:0]    merged_board, spawn_board;
  logic                  spawn_found;
  cell_idx_t             spawn_idx;
  exp_t                  spawn_val;
  logic                  won, lost, has_empty, has_pair;

  line_merge u_line_merge (
    .line_i (line_in),
    .line_o (line_out)
  );

  // Gather the active line out of the working board.
  always_comb begin
    for (int e = 0; e < 4; e++) begin
      line_in[e] = get_cell(board_q, cell_index(dir_q, line_q, 2'(e)));
    end
  end

  // Scatter the merged line back into its cells.
  always_comb begin
    merged_board = board_q;
    for (int e = 0; e < 4; e++) begin
      merged_board = set_cell(merged_board, cell_index(dir_q, line_q, 2'(e)), line_out[e]);
    end
  end

  // Descending scan so the empty cell nearest lfsr[3:0] (wrapping) is the one kept.
  always_comb begin
    spawn_found = 1'b0;
    spawn_idx   = '0;
    for (int j = CELLS - 1; j >= 0; j--) begin
      if (get_cell(board_q, lfsr_q[3:0] + 4'(j)) == '0) begin
        spawn_found = 1'b1;
        spawn_idx   = lfsr_q[3:0] + 4'(j);
      end else begin
        spawn_found = spawn_found;
      end
    end
    spawn_val   = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
    spawn_board = spawn_found ? set_cell(board_q, spawn_idx, spawn_val) : board_q;
  end

  // Win/lose evaluation on the board the boxes hold after the write.
  always_comb begin
    won       = 1'b0;
    has_empty = 1'b0;
    has_pair  = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      if (get_cell(oldvalues, 4'(i)) >= EXP_W'(WIN_EXP)) won = 1'b1;
      else won = won;
      if (get_cell(oldvalues, 4'(i)) == '0) has_empty = 1'b1;
      else has_empty = has_empty;
      if (((i % 4) != 3) && (get_cell(oldvalues, 4'(i)) == get_cell(oldvalues, 4'(i + 1))))
        has_pair = 1'b1;
      else has_pair = has_pair;
      if ((i < 12) && (get_cell(oldvalues, 4'(i)) == get_cell(oldvalues, 4'(i + 4))))
        has_pair = 1'b1;
      else has_pair = has_pair;
    end
    lost = !has_empty && !has_pair;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    saved_d     = saved_q;
    line_d      = line_q;
    dir_d       = dir_q;
    armed_d     = armed_q | (direction == 4'd0);
    endstatus_d = endstatus_q;
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    case (state_q)
      ST_INIT: begin
        board_d = spawn_board;
        if (line_q[0]) begin
          line_d  = 2'd0;
          state_d = ST_WRITE;
        end else begin
          line_d = line_q + 2'd1;
        end
      end
      ST_IDLE: begin
        if (is_onehot4(direction) && armed_q) begin
          dir_d   = direction;
          armed_d = 1'b0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        board_d = oldvalues;
        saved_d = oldvalues;
        line_d  = 2'd0;
        state_d = ST_LINE;
      end
      ST_LINE: begin
        board_d = merged_board;
        line_d  = line_q + 2'd1;
        if (line_q == 2'd3) begin
          state_d = (merged_board == saved_q) ? ST_IDLE : ST_SPAWN;
        end else begin
          state_d = ST_LINE;
        end
      end
      ST_SPAWN: begin
        board_d = spawn_board;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (won) begin
          endstatus_d = ES_WON;
          state_d     = ST_OVER;
        end else if (lost) begin
          endstatus_d = ES_LOST;
          state_d     = ST_OVER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_INIT;
    endcase
    // Strobe and board are registered on entry so they line up with the WRITE cycle.
    enable_d    = (state_d == ST_WRITE);
    newvalues_d = (state_d == ST_WRITE) ? board_d : newvalues_q;
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      state_q     <= ST_INIT;
      board_q     <= '0;
      saved_q     <= '0;
      newvalues_q <= '0;
      line_q      <= 2'd0;
      endstatus_q <= ES_PLAY;
      dir_q       <= 4'd0;
      lfsr_q      <= LFSR_SEED;
      armed_q     <= 1'b1;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      saved_q     <= saved_d;
      newvalues_q <= newvalues_d;
      line_q      <= line_d;
      endstatus_q <= endstatus_d;
      dir_q       <= dir_d;
      lfsr_q      <= lfsr_d;
      armed_q     <= armed_d;
      enable_q    <= enable_d;
    end
  end

  assign enable    = enable_q;
  assign newvalues = newvalues_q;
  assign endstatus = endstatus_q;
  assign state     = state_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer with a behavioural box bank and reference LFSR.
module tb_move_sequencer;

  logic        clock = 1'b0;
  logic        start = 1'b1;
  logic [3:0]  direction = 4'd0;
  logic [63:0] oldvalues;
  logic        enable;
  logic [63:0] newvalues;
  logic [1:0]  endstatus;
  logic [2:0]  state;

  logic [63:0] boxes;
  logic        preload_en = 1'b0;
  logic [63:0] preload_val = 64'd0;
  logic [15:0] lfsr_m;

  int checks = 0;
  int passes = 0;
  int en_count = 0;

  typedef struct {
    logic [63:0] pre;
    int          nsp;
    int          tag;
  } sb_entry_t;

  sb_entry_t   expq[$];
  logic [15:0] spq[$];

  move_sequencer #(.WIN_EXP(11), .LFSR_SEED(16'hACE1)) dut (
    .clock     (clock),
    .start     (start),
    .direction (direction),
    .oldvalues (oldvalues),
    .enable    (enable),
    .newvalues (newvalues),
    .endstatus (endstatus),
    .state     (state)
  );

  always #5 clock = ~clock;

  assign oldvalues = boxes;

  always @(posedge clock or posedge start) begin
    if (start) boxes <= 64'd0;
    else if (preload_en) boxes <= preload_val;
    else if (enable) boxes <= newvalues;
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [63:0] m_spawn(input logic [63:0] b, input logic [15:0] l);
    logic [63:0] r;
    r = b;
    for (int j = 0; j < 16; j++) begin
      int i;
      i = (int'(l[3:0]) + j) % 16;
      if (r[63-4*i -: 4] == 4'd0) begin
        r[63-4*i -: 4] = (l[7:4] == 4'd0) ? 4'd2 : 4'd1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic int count_tiles(input logic [63:0] b);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) if (b[63-4*i -: 4] != 4'd0) c++;
    return c;
  endfunction

  // Reference LFSR; records the value in use on every spawning cycle.
  always @(posedge clock or posedge start) begin
    if (start) begin
      lfsr_m <= 16'hACE1;
      spq.delete();
    end else begin
      if (state == 3'd3 || state == 3'd7) spq.push_back(lfsr_m);
      lfsr_m <= lfsr_next(lfsr_m);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else passes++;
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    sb_entry_t   e;
    logic [63:0] b;
    if (enable === 1'b1) begin
      en_count++;
      if (expq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_enable: got newvalues %h with no pending move", newvalues);
      end else begin
        e = expq.pop_front();
        b = e.pre;
        for (int n = 0; n < e.nsp; n++) begin
          if (spq.size() == 0) begin
            checks++;
            $display("FAIL spawn_missing_tag%0d: got no spawn cycle, expected %0d", e.tag, e.nsp);
          end else begin
            b = m_spawn(b, spq.pop_front());
          end
        end
        chk($sformatf("newvalues_tag%0d", e.tag), newvalues, b);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_exp(input logic [63:0] pre, input int nsp, input int tag);
    sb_entry_t e;
    e.pre = pre;
    e.nsp = nsp;
    e.tag = tag;
    expq.push_back(e);
  endtask

  task automatic do_reset();
    int ens;
    start     = 1'b1;
    direction = 4'd0;
    tick(2);
    chk("reset_state", state, 7);
    chk("reset_enable", enable, 0);
    chk("reset_newvalues", newvalues, 0);
    chk("reset_endstatus", endstatus, 0);
    push_exp(64'd0, 2, 0);
    start = 1'b0;
    ens = 0;
    for (int t = 1; t <= 4; t++) begin
      tick(1);
      if (enable) ens++;
      if (t == 2) chk("init_write_state", state, 4);
    end
    chk("init_enable_count", ens, 1);
    chk("init_idle_state", state, 0);
    chk("init_endstatus", endstatus, 0);
    chk("init_tile_count", count_tiles(boxes), 2);
  endtask

  task automatic do_move(input logic [3:0] dir, input logic [63:0] pre, input logic [63:0] merged,
                         input logic changes, input logic [2:0] end_state,
                         input logic [1:0] end_es, input int tag);
    int ens;
    ens = 0;
    direction   = 4'd0;
    preload_val = pre;
    preload_en  = 1'b1;
    tick(1);
    preload_en = 1'b0;
    chk($sformatf("t%0d_idle_before", tag), state, 0);
    if (changes) push_exp(merged, 1, tag);
    direction = dir;
    for (int t = 1; t <= 9; t++) begin
      tick(1);
      if (enable) ens++;
      if (t == 7) chk($sformatf("t%0d_enable_cycle7", tag), enable, changes);
      if (t == 6 && !changes) chk($sformatf("t%0d_nochange_idle", tag), state, 0);
      if (t == 9) begin
        chk($sformatf("t%0d_state_after", tag), state, changes ? end_state : 3'd0);
        chk($sformatf("t%0d_endstatus", tag), endstatus, end_es);
      end
    end
    chk($sformatf("t%0d_enable_count", tag), ens, changes);
    if (!changes) chk($sformatf("t%0d_board_kept", tag), boxes, pre);
    direction = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int busy;
    do_reset();

    do_move(4'b0010, 64'h1120_0000_0000_0000, 64'h2200_0000_0000_0000, 1'b1, 3'd0, 2'b00, 1);
    do_move(4'b0001, 64'h1111_0000_0000_0000, 64'h0022_0000_0000_0000, 1'b1, 3'd0, 2'b00, 2);
    do_move(4'b1000, 64'h3000_0000_3000_0000, 64'h4000_0000_0000_0000, 1'b1, 3'd0, 2'b00, 3);
    do_move(4'b0010, 64'h0000_0303_0000_0000, 64'h0000_4000_0000_0000, 1'b1, 3'd0, 2'b00, 4);
    do_move(4'b0100, 64'h0000_0010_0010_0020, 64'h0000_0000_0020_0020, 1'b1, 3'd0, 2'b00, 5);
    do_move(4'b0010, 64'h1000_2000_3000_1000, 64'h1000_2000_3000_1000, 1'b0, 3'd0, 2'b00, 6);
    do_move(4'b0010, 64'hFF00_0000_0000_0000, 64'hFF00_0000_0000_0000, 1'b0, 3'd0, 2'b00, 7);

    // A held key produces one move; a two-bit direction is ignored.
    preload_val = 64'h0000_1000_0000_0000;
    preload_en  = 1'b1;
    tick(1);
    preload_en = 1'b0;
    push_exp(64'h1000_0000_0000_0000, 1, 8);
    base = en_count;
    direction = 4'b1000;
    tick(50);
    chk("hold_one_move", en_count - base, 1);
    chk("hold_idle", state, 0);
    direction = 4'd0;
    tick(2);
    direction = 4'b0011;
    busy = 0;
    for (int t = 0; t < 20; t++) begin
      tick(1);
      if (state != 3'd0) busy++;
    end
    chk("multibit_ignored", busy, 0);
    do_move(4'b1000, 64'h0000_1000_0000_0000, 64'h1000_0000_0000_0000, 1'b1, 3'd0, 2'b00, 9);

    do_move(4'b0010, 64'hAA00_0000_0000_0000, 64'hB000_0000_0000_0000, 1'b1, 3'd6, 2'b01, 10);
    direction = 4'b0100;
    busy = 0;
    for (int t = 0; t < 12; t++) begin
      tick(1);
      if (state != 3'd6) busy++;
    end
    chk("over_holds_state", busy, 0);
    chk("over_endstatus", endstatus, 1);

    // Reset in the middle of a move discards it and re-runs the start-up sequence.
    do_reset();
    preload_val = 64'h1120_0000_0000_0000;
    preload_en  = 1'b1;
    tick(1);
    preload_en = 1'b0;
    direction  = 4'b0010;
    tick(3);
    chk("midreset_in_line", state, 2);
    do_reset();

    tick(3);
    chk("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
